// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Iterative sequencer for the RISC-V M extension (mul/mulh/mulhsu/mulhu,
// div/divu/rem/remu). Signed operands are turned into magnitudes, then
// processed one radix-2 step per cycle. The sign is restored at the end.
//
// Sequence: IDLE -> PREP -> CALC (XLEN cycles) -> FIX -> DONE -> IDLE.
//
// Ports:
//   CLK       rising-edge clock
//   RESET     asynchronous, active-low reset
//   START     request from EX to begin an operation
//   ALU_OP    5-bit M-extension opcode
//   OPERAND1  rs1 value (XLEN bits)
//   OPERAND2  rs2 value (XLEN bits)
//   FLUSH     aborts any operation in flight
//   BUSY      high whenever the FSM is not IDLE
//   STALL     combinational pipeline hold request
//   DONE      registered one-cycle result-valid strobe
//   RESULT    registered result, held until the next load
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When it is defined, the mul-class ops use a single-cycle multiplier
//   (IDLE -> DONE) and the shift-add path is left out. Divide is unchanged.

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALU_OP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [2:0]      kind;       // ALU_OP[4:2]: bit 2 selects divide, [1:0] selects the variant
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [CW-1:0]   cnt;
    logic            neg_main;
    logic            neg_rem;
    logic            div_zero;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Every M code has bit 0 set and bit 1 clear. The other three bits
    // cover all eight ops, so this is the complete validity check.
    logic valid_op;
    assign valid_op = ALU_OP[0] & ~ALU_OP[1];

    assign BUSY   = (state != S_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

    // The hold request covers the accepting IDLE cycle and the working states.
    // It drops in DONE so the pipeline captures RESULT.
    always_comb begin
        STALL = 1'b0;
        if (!FLUSH) begin
            case (state)
                S_IDLE:                STALL = START & valid_op;
                S_PREP, S_CALC, S_FIX: STALL = 1'b1;
                default:               STALL = 1'b0;
            endcase
        end
    end

    // Signedness per op. mulhsu treats only rs1 as signed.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    always_comb begin
        a_signed = (kind == 3'b001) || (kind == 3'b011) || (kind == 3'b100) || (kind == 3'b110);
        b_signed = (kind == 3'b001) || (kind == 3'b100) || (kind == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
    end

    // One radix-2 step.
    // Divide is restoring: shift {rem, dividend} left and subtract the divisor
    // when it fits. The extra top bit of rem_shift keeps the comparison exact.
    // Multiply is shift-add: the multiplier sits in acc_lo, and the carry out
    // of the add moves into the top bit on the right shift.
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] step_next;
`ifndef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     mul_sum;
`endif
    always_comb begin
        rem_shift = {acc_hi, acc_lo[XLEN-1]};
        rem_sub   = rem_shift[XLEN-1:0] - op_b;
        if (rem_shift >= {1'b0, op_b})
            step_next = {rem_sub, acc_lo[XLEN-2:0], 1'b1};
        else
            step_next = {rem_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
`ifndef MULDIV_FAST_MUL_EN
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(XLEN+1){1'b0}});
        if (!kind[2])
            step_next = {mul_sum, acc_lo[XLEN-1:1]};
`endif
    end

    // Sign correction and result-word selection for the FIX load.
    // Divide by zero forces an all-ones quotient. The remainder of a divide by
    // zero is already |rs1|, so the normal sign fix gives rs1 back. The
    // overflow case comes out as 0x80000000 rem 0 without special handling.
    logic [XLEN-1:0]   quot, remv, fix_result;
`ifndef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fix;
`endif
    always_comb begin
        quot = div_zero ? {XLEN{1'b1}} : (neg_main ? -acc_lo : acc_lo);
        remv = neg_rem ? -acc_hi : acc_hi;
`ifndef MULDIV_FAST_MUL_EN
        prod_fix = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        case (kind)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot;
            default:                fix_result = remv;
        endcase
`else
        case (kind)
            3'b100, 3'b101: fix_result = quot;
            default:        fix_result = remv;
        endcase
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle multiply on the raw inputs. The operands are sign- or
    // zero-extended to 2*XLEN, so one unsigned multiply covers all variants.
    logic              fa_signed, fb_signed;
    logic [2*XLEN-1:0] fa_ext, fb_ext, fast_prod;
    logic [XLEN-1:0]   fast_res;
    always_comb begin
        fa_signed = ALU_OP[2];
        fb_signed = (ALU_OP[3:2] == 2'b01);
        fa_ext    = {{XLEN{fa_signed & OPERAND1[XLEN-1]}}, OPERAND1};
        fb_ext    = {{XLEN{fb_signed & OPERAND2[XLEN-1]}}, OPERAND2};
        fast_prod = fa_ext * fb_ext;
        fast_res  = (ALU_OP[3:2] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Main sequencer. FLUSH overrides every state and returns to IDLE without
    // a DONE pulse. RESULT changes only on the FIX load (or the fast load).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            kind     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (FLUSH) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START && valid_op) begin
                        kind  <= ALU_OP[4:2];
                        op_a  <= OPERAND1;
                        op_b  <= OPERAND2;
                        state <= S_PREP;
`ifdef MULDIV_FAST_MUL_EN
                        if (!ALU_OP[4]) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end
`endif
                    end
                end
                S_PREP: begin
                    op_a     <= mag_a;
                    op_b     <= mag_b;
                    acc_hi   <= '0;
                    acc_lo   <= kind[2] ? mag_a : mag_b;
                    neg_main <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    div_zero <= (op_b == '0);
                    cnt      <= CW'(XLEN);
                    state    <= S_CALC;
                end
                S_CALC: begin
                    {acc_hi, acc_lo} <= step_next;
                    cnt              <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// -------------------
// Directed bench for muldiv_sequencer with XLEN=32. Each START pushes a
// reference result onto a scoreboard queue. The matching DONE pops it and
// compares it with RESULT. Latency and STALL coverage are checked on each op.
// It also exercises FLUSH, FLUSH+START, non-M codes and reset in CALC.
// Follows MULDIV_FAST_MUL_EN for the expected mul-class latency.

module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b00001;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01001;
    localparam logic [4:0] OP_DIV    = 5'b10001;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b11001;
    localparam logic [4:0] OP_REMU   = 5'b11101;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [4:0]      ALU_OP;
    logic [XLEN-1:0] OPERAND1;
    logic [XLEN-1:0] OPERAND2;
    logic            FLUSH;
    logic            BUSY;
    logic            STALL;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastExp = '0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .ALU_OP   (ALU_OP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .FLUSH    (FLUSH),
        .BUSY     (BUSY),
        .STALL    (STALL),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    // Hard time limit so a hung DUT still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model built on 64-bit host arithmetic.
    function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            OP_REMU:   return (b == 32'h0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one operation and follows it to its DONE strobe.
    // With holdStart set, START stays high (with a mul code) while busy, and
    // must be ignored until the IDLE cycle after DONE.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input bit holdStart);
        int          n;
        int          stallCnt;
        int          expLat;
        bit          seen;
        logic [31:0] exp;
        @(negedge CLK);
        START    = 1'b1;
        ALU_OP   = op;
        OPERAND1 = a;
        OPERAND2 = b;
        expQ.push_back(refModel(op, a, b));
        #1 checkOutput({tag, "_accept_stall"}, {31'b0, STALL}, 32'd1);
        @(posedge CLK);
        #1;
        if (holdStart) begin
            ALU_OP   = OP_MUL;
            OPERAND1 = 32'h1234_5678;
            OPERAND2 = 32'h0000_0003;
        end else begin
            START  = 1'b0;
            ALU_OP = 5'b00000;
        end
        n        = 0;
        stallCnt = 0;
        seen     = 1'b0;
        while (!seen && n < 100) begin
            @(negedge CLK);
            n++;
            if (DONE) seen = 1'b1;
            else if (STALL) stallCnt++;
        end
        START  = 1'b0;
        ALU_OP = 5'b00000;
        // DONE arrives XLEN+3 edges after sampling, counting the START edge,
        // so every preceding cycle from PREP through FIX stalls.
        expLat = XLEN + 3;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[4]) expLat = 1;
`endif
        checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
        checkOutput({tag, "_stall_cycles"}, 32'(stallCnt), 32'(expLat - 1));
        if (expQ.size() > 0) exp = expQ.pop_front();
        else exp = 'x;
        if (seen) begin
            lastExp = exp;
            checkOutput({tag, "_result"}, RESULT, exp);
            checkOutput({tag, "_done_stall"}, {31'b0, STALL}, 32'd0);
            @(negedge CLK);
            checkOutput({tag, "_done_pulse_end"}, {31'b0, DONE}, 32'd0);
            checkOutput({tag, "_result_hold"}, RESULT, exp);
            checkOutput({tag, "_idle_busy"}, {31'b0, BUSY}, 32'd0);
        end
    endtask

    initial begin
        int         doneCnt;
        logic [4:0] opTable[8];
        logic [4:0] rop;
        logic [31:0] ra, rb;
        opTable = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        RESET    = 1'b0;
        START    = 1'b0;
        FLUSH    = 1'b0;
        ALU_OP   = 5'b00000;
        OPERAND1 = '0;
        OPERAND2 = '0;
        #12;
        checkOutput("reset_busy",   {31'b0, BUSY},  32'd0);
        checkOutput("reset_done",   {31'b0, DONE},  32'd0);
        checkOutput("reset_result", RESULT,         32'd0);
        checkOutput("reset_stall",  {31'b0, STALL}, 32'd0);

        // Release mid-phase, so the first START lands on the first edge after release.
        @(posedge CLK);
        #2 RESET = 1'b1;

        applyStimulus(OP_DIV,    32'hFFFF_FFEC, 32'd3,        "div_m20_3",   1'b0);
        applyStimulus(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf",    1'b1);
        applyStimulus(OP_DIVU,   32'd7,         32'd0,         "divu_zero",  1'b0);
        applyStimulus(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min",   1'b0);
        applyStimulus(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max",  1'b0);
        applyStimulus(OP_MUL,    32'hFFFF_FFFD, 32'd7,         "mul_neg",    1'b0);
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_mix", 1'b0);
        applyStimulus(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",    1'b0);
        applyStimulus(OP_DIV,    32'hFFFF_FFFB, 32'd0,         "div_zero",   1'b0);
        applyStimulus(OP_REM,    32'hFFFF_FFFB, 32'd0,         "rem_zero",   1'b0);
        applyStimulus(OP_REMU,   32'hFFFF_FFFB, 32'd10,        "remu_big",   1'b0);
        applyStimulus(OP_REM,    32'hFFFF_FFEC, 32'hFFFF_FFFD, "rem_negneg", 1'b0);

        for (int i = 0; i < 6; i++) begin
            rop = opTable[$urandom_range(7, 0)];
            ra  = $urandom;
            rb  = (i == 2) ? 32'd0 : $urandom;
            applyStimulus(rop, ra, rb, $sformatf("rand%0d", i), 1'b0);
        end

        // FLUSH and START together in IDLE: FLUSH wins.
        @(negedge CLK);
        START    = 1'b1;
        FLUSH    = 1'b1;
        ALU_OP   = OP_DIV;
        OPERAND1 = 32'd100;
        OPERAND2 = 32'd7;
        #1 checkOutput("flush_start_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK);
        #1 checkOutput("flush_start_busy", {31'b0, BUSY}, 32'd0);
        START = 1'b0;
        FLUSH = 1'b0;

        // Non-M code is ignored.
        @(negedge CLK);
        START  = 1'b1;
        ALU_OP = 5'b00011;
        #1 checkOutput("nonm_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK);
        #1 checkOutput("nonm_busy", {31'b0, BUSY}, 32'd0);
        START  = 1'b0;
        ALU_OP = 5'b00000;

        // FLUSH in CALC cycle 10 of div 100/7 (CALC starts in the second cycle).
        @(negedge CLK);
        START    = 1'b1;
        ALU_OP   = OP_DIV;
        OPERAND1 = 32'd100;
        OPERAND2 = 32'd7;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (11) @(negedge CLK);
        checkOutput("flush_busy_before", {31'b0, BUSY}, 32'd1);
        FLUSH = 1'b1;
        #1 checkOutput("flush_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK);
        #1 FLUSH = 1'b0;
        checkOutput("flush_busy_after", {31'b0, BUSY}, 32'd0);
        doneCnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) doneCnt++;
        end
        checkOutput("flush_no_done", 32'(doneCnt), 32'd0);
        checkOutput("flush_result_kept", RESULT, lastExp);
        applyStimulus(OP_DIV, 32'd100, 32'd7, "div_100_7", 1'b0);

        // Reset during CALC clears outputs immediately, with no later DONE.
        @(negedge CLK);
        START    = 1'b1;
        ALU_OP   = OP_DIVU;
        OPERAND1 = 32'd1000;
        OPERAND2 = 32'd9;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (15) @(negedge CLK);
        checkOutput("rst_busy_before", {31'b0, BUSY}, 32'd1);
        RESET = 1'b0;
        #1;
        checkOutput("rst_busy",   {31'b0, BUSY}, 32'd0);
        checkOutput("rst_result", RESULT,        32'd0);
        checkOutput("rst_done",   {31'b0, DONE}, 32'd0);
        START  = 1'b1;
        ALU_OP = 5'b00000;
        #1 checkOutput("rst_nonm_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK);
        #2 RESET = 1'b1;
        @(posedge CLK);
        #1 checkOutput("rst_nonm_busy", {31'b0, BUSY}, 32'd0);
        START = 1'b0;
        doneCnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) doneCnt++;
        end
        checkOutput("rst_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(OP_MULHU, 32'h0001_0000, 32'h0001_0000, "after_rst", 1'b0);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have the port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port START, input, 1 bit: EX-stage request to begin an M-extension operation.
REQ-005 The block SHALL have the port ALU_OP, input, 5 bits, with these codes: mul 00001, mulh 00101, mulhsu 01101, mulhu 01001, div 10001, divu 10101, rem 11001, remu 11101.
REQ-006 The block SHALL have the ports OPERAND1 and OPERAND2, inputs, XLEN bits each: rs1 and rs2 values.
REQ-007 The block SHALL have the port FLUSH, input, 1 bit: aborts any operation in flight.
REQ-008 The block SHALL have the port BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have the port STALL, output, 1 bit: combinational hold request to the pipeline.
REQ-010 The block SHALL have the port DONE, output, 1 bit, registered: single-cycle result-valid strobe.
REQ-011 The block SHALL have the port RESULT, output, XLEN bits, registered: operation result.

Function
REQ-012 The FSM SHALL have the states IDLE, PREP, CALC, FIX and DONE.
REQ-013 In IDLE, START high with a valid M code and FLUSH low SHALL latch the operands and op, then move to PREP.
- With MULDIV_FAST_MUL_EN defined, a mul-class op moves directly to DONE instead.
REQ-014 START with a non-M ALU_OP code SHALL be ignored, with no state change and STALL low.
REQ-015 START received outside IDLE SHALL be ignored.
REQ-016 PREP SHALL take 1 cycle: record the result sign and convert signed operands to magnitudes (mulhsu: only OPERAND1 is treated as signed).
REQ-017 CALC SHALL take exactly XLEN cycles, one radix-2 step per cycle, counted by a counter of width clog2(XLEN)+1.
- Multiply: shift-add into a 2*XLEN product.
- Divide: restoring divide, giving quotient and remainder.
REQ-018 FIX SHALL take 1 cycle: apply sign correction, select the result word, and load RESULT.
- mul: low XLEN bits.
- mulh/mulhsu/mulhu: high XLEN bits.
- div/divu: quotient.
- rem/remu: remainder.
REQ-019 DONE SHALL last 1 cycle with DONE=1, then the FSM returns to IDLE.
REQ-020 Latency from the START sampling edge to the DONE cycle SHALL be fixed at XLEN+3 edges for all non-fast operations, special cases included.
REQ-021 Divide by zero SHALL give a quotient of all ones and a remainder equal to OPERAND1 (signed and unsigned).
REQ-022 Signed overflow (-2^(XLEN-1) / -1) SHALL give a quotient of 0x80000000 and a remainder of 0.
REQ-023 STALL SHALL be high in the IDLE cycle that accepts START, and in PREP, CALC and FIX.
- STALL SHALL be low in DONE, so the pipeline advances and captures RESULT in that cycle.
REQ-024 RESULT SHALL hold its value from the FIX-edge load until the next load.
REQ-025 FLUSH high in any state SHALL force IDLE on the next edge with no DONE pulse and RESULT unchanged.
- STALL SHALL be low while FLUSH is high.
REQ-026 FLUSH and START high in the same IDLE cycle: FLUSH SHALL win, and the operation SHALL not start.
REQ-027 A new START SHALL be accepted no earlier than the IDLE cycle that follows DONE.

Reset
REQ-028 While RESET is low, the block SHALL hold state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0 and internal operand registers=0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL abandon the operation, with no DONE pulse after release.
REQ-030 The block SHALL accept START on the first rising edge after RESET deasserts.

Configuration
REQ-031 With MULDIV_FAST_MUL_EN defined, mul-class ops SHALL use a single-cycle multiplier.
- The block goes IDLE -> DONE, and DONE is high in the cycle after the START edge.
- The shift-add multiply path SHALL be omitted.
REQ-032 Without MULDIV_FAST_MUL_EN, all eight ops SHALL use the iterative path with XLEN+3 latency.
REQ-033 Divide behaviour SHALL be identical with and without MULDIV_FAST_MUL_EN.

Verification
REQ-034 div: START, ALU_OP=10001, OPERAND1=-20 (0xFFFFFFEC), OPERAND2=3 -> DONE exactly 35 edges later, RESULT=0xFFFFFFFA (-6), STALL high for the 34 preceding cycles.
REQ-035 rem, then divu by zero:
- rem (11001), 0x80000000 / 0xFFFFFFFF -> RESULT=0.
- divu (10101), 7 / 0 -> RESULT=0xFFFFFFFF, with latency still 35.
REQ-036 mulh (00101), 0x80000000 x 0x80000000 -> RESULT=0x40000000.
- mulhu (01001), 0xFFFFFFFF x 0xFFFFFFFF -> RESULT=0xFFFFFFFE.
- Latency: 1 with the macro, 35 without.
REQ-037 FLUSH pulsed at CALC cycle 10 of div 100/7 -> IDLE next edge, no DONE, RESULT unchanged; a following START of 100/7 -> RESULT=14.
REQ-038 RESET driven low during CALC -> BUSY=0 and RESULT=0 immediately, before the next clock edge; START with ALU_OP=00000 -> STALL=0 and BUSY stays 0.
